// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The slave modport is the subtractor side; state is exported for observation.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;
    logic             Overflow;
    logic [0:0]       state;

    modport master (
        output start, A, B, bin,
        input  busy, done, D, bout, Overflow, state
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, D, bout, Overflow, state
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - bin over WIDTH RUN cycles,
// with start/busy/done handshake, unsigned borrow-out and signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Handshake: start is accepted on an edge where busy=0; done pulses for
    // one cycle after the final bit, coincident with the idle cycle in which
    // a new start can already be accepted.
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic bit_a, bit_b, diff_bit, borrow_next;

    assign bit_a       = a_sh_q[0];
    assign bit_b       = b_sh_q[0];
    assign diff_bit    = bit_a ^ bit_b ^ borrow_q;
    assign borrow_next = (~bit_a & bit_b) | (~bit_a & borrow_q) | (bit_b & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.A;
                    b_sh_d   = bus.B;
                    a_msb_d  = bus.A[WIDTH-1];
                    b_msb_d  = bus.B[WIDTH-1];
                    borrow_d = bus.bin;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_d    = {diff_bit, res_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = borrow_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // The final difference bit is the result sign bit.
                    d_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_next;
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;
    assign bus.D        = d_q;
    assign bus.bout     = bout_q;
    assign bus.Overflow = ovf_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): handshake timing, borrow,
// overflow, ignored start, back-to-back, mid-run reset and a corner sweep.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from a negedge; returns samples until done
    // (lat, -1 on timeout) and the number of busy samples before done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          output int lat, output int busy_n);
        bus.A = a; bus.B = b; bus.bin = bi; bus.start = 1'b1;
        lat = -1; busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.D, bus.bout, bus.Overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b D=%h bout=%b ovf=%b, want all 0",
                     bus.busy, bus.done, bus.D, bus.bout, bus.Overflow);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bn;
        run_op(8'h05, 8'h03, 1'b0, lat, bn);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL basic_latency: got %0d, want 9", lat);
        end
        checks++;
        if (bn !== 8) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
        end
        checks++;
        if ({bus.D, bus.bout, bus.Overflow, bus.busy} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got D=%h bout=%b ovf=%b busy=%b, want D=02 bout=0 ovf=0 busy=0",
                     bus.D, bus.bout, bus.Overflow, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL basic_done_width: got done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_borrow;
        int lat, bn;
        run_op(8'h03, 8'h05, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || {bus.D, bus.bout, bus.Overflow} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL borrow_03_05: got lat=%0d D=%h bout=%b ovf=%b, want lat=9 D=fe bout=1 ovf=0",
                     lat, bus.D, bus.bout, bus.Overflow);
        end
    endtask

    task automatic test_overflow;
        int lat, bn;
        run_op(8'h80, 8'h01, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || {bus.D, bus.bout, bus.Overflow} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_80_01: got lat=%0d D=%h bout=%b ovf=%b, want lat=9 D=7f bout=0 ovf=1",
                     lat, bus.D, bus.bout, bus.Overflow);
        end
        run_op(8'h7F, 8'hFF, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || {bus.D, bus.bout, bus.Overflow} !== {8'h80, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_7f_ff: got lat=%0d D=%h bout=%b ovf=%b, want lat=9 D=80 bout=1 ovf=1",
                     lat, bus.D, bus.bout, bus.Overflow);
        end
    endtask

    task automatic test_bin;
        int lat, bn;
        run_op(8'h00, 8'h00, 1'b1, lat, bn);
        checks++;
        if (lat !== 9 || {bus.D, bus.bout, bus.Overflow} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bin_00_00_1: got lat=%0d D=%h bout=%b ovf=%b, want lat=9 D=ff bout=1 ovf=0",
                     lat, bus.D, bus.bout, bus.Overflow);
        end
    endtask

    // Starts 0x10-0x04 (=0x0c); a stray start and operand changes mid-run must not matter.
    task automatic test_busy_start;
        int dones;
        bus.A = 8'h10; bus.B = 8'h04; bus.bin = 1'b0; bus.start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            bus.start = (i == 3);
            if (i >= 2) begin bus.A = 8'hC3; bus.B = 8'h5A; bus.bin = 1'b1; end
            if (i == 3) begin
                checks++;
                if (bus.D !== 8'hFF) begin
                    errors++; $display("FAIL hold_during_run: got D=%h, want ff", bus.D);
                end
            end
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL busy_start_done_count: got %0d, want 1", dones);
        end
        checks++;
        if ({bus.D, bus.bout, bus.Overflow} !== {8'h0C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL busy_start_result: got D=%h bout=%b ovf=%b, want D=0c bout=0 ovf=0",
                     bus.D, bus.bout, bus.Overflow);
        end
        bus.bin = 1'b0;
    endtask

    // start held high: 0x09-0x04 then 0x40-0x41, done pulses 9 cycles apart.
    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        bus.A = 8'h09; bus.B = 8'h04; bus.bin = 1'b0; bus.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done && first < 0) begin
                first = i;
                checks++;
                if ({bus.D, bus.bout, bus.Overflow} !== {8'h05, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_first: got D=%h bout=%b ovf=%b, want D=05 bout=0 ovf=0",
                             bus.D, bus.bout, bus.Overflow);
                end
                bus.A = 8'h40; bus.B = 8'h41;
            end else if (bus.done) begin
                second = i;
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first < 0 || second - first !== 9) begin
            errors++; $display("FAIL b2b_spacing: got first=%0d second=%0d, want gap 9", first, second);
        end
        checks++;
        if ({bus.D, bus.bout, bus.Overflow} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got D=%h bout=%b ovf=%b, want D=ff bout=1 ovf=0",
                     bus.D, bus.bout, bus.Overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        bus.A = 8'h22; bus.B = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.D, bus.bout, bus.Overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b D=%h bout=%b ovf=%b, want all 0",
                     bus.busy, bus.done, bus.D, bus.bout, bus.Overflow);
        end
        @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d busy/done samples, want 0", dones);
        end
    endtask

    task automatic test_sweep;
        logic [W-1:0] vals [8];
        logic [W:0]   exp_full;
        logic         exp_ovf;
        int           lat, bn;
        vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h55, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                for (int k = 0; k < 2; k++) begin
                    exp_full = {1'b0, vals[i]} - {1'b0, vals[j]} - (W+1)'(k);
                    exp_ovf  = (vals[i][W-1] != vals[j][W-1]) && (exp_full[W-1] != vals[i][W-1]);
                    run_op(vals[i], vals[j], k[0], lat, bn);
                    checks++;
                    if (lat !== 9 || {bus.bout, bus.D, bus.Overflow} !== {exp_full, exp_ovf}) begin
                        errors++;
                        $display("FAIL sweep %h-%h-%0d: got lat=%0d bout=%b D=%h ovf=%b, want lat=9 bout=%b D=%h ovf=%b",
                                 vals[i], vals[j], k, lat, bus.bout, bus.D, bus.Overflow,
                                 exp_full[W], exp_full[W-1:0], exp_ovf);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_borrow;
        test_overflow;
        test_bin;
        test_busy_start;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
